// File: rtl/seven_seg_controller_pkg.sv
// Shared constants for the four-digit seven-segment display path.
// Patterns are stored active-low (bit0 = a ... bit6 = g); polarity is applied per instance.
package seven_seg_controller_pkg;

   localparam int SEG_W  = 7;
   localparam int DIGITS = 4;
   localparam int NIB_W  = 4;
   localparam int DATA_W = DIGITS * NIB_W;
   localparam int DISP_W = DIGITS * SEG_W;

   // All segments dark, in the active-low storage form.
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

   localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [SEG_W-1:0] seg_polarity(input logic [SEG_W-1:0] pat,
                                                      input bit             active_low);
      return active_low ? pat : ~pat;
   endfunction

endpackage

// File: rtl/seven_seg_controller_hex_to_seg.sv
// Combinational hex nibble to seven-segment pattern decoder.
module hex_to_seg
   import seven_seg_controller_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic [NIB_W-1:0] hex_i,
   output logic [SEG_W-1:0] seg_o
);

   always_comb begin
      seg_o = seg_polarity(SEG_TABLE[hex_i], SEG_ACTIVE_LOW);
   end

endmodule

// File: rtl/seven_seg_controller.sv
// Selects one of eight 16-bit registers and shows it as four hex digits,
// with a single output register between the inputs and the display.
module seven_seg_controller
   import seven_seg_controller_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        sw,
   input  logic [DATA_W-1:0] r1,
   input  logic [DATA_W-1:0] r2,
   input  logic [DATA_W-1:0] r3,
   input  logic [DATA_W-1:0] r4,
   input  logic [DATA_W-1:0] r5,
   input  logic [DATA_W-1:0] r6,
   input  logic [DATA_W-1:0] r7,
   input  logic [DATA_W-1:0] r8,
   output logic [DISP_W-1:0] displ
);

   localparam logic [DISP_W-1:0] DISP_BLANK =
      {DIGITS{seg_polarity(SEG_BLANK, SEG_ACTIVE_LOW)}};

   logic [DATA_W-1:0] sel_v;
   logic [DISP_W-1:0] displ_d;
   logic [DISP_W-1:0] displ_q;

   // Every sw code maps to a register, so the case is complete without a default.
   always_comb begin
      case (sw)
         3'd0: sel_v = r1;
         3'd1: sel_v = r2;
         3'd2: sel_v = r3;
         3'd3: sel_v = r4;
         3'd4: sel_v = r5;
         3'd5: sel_v = r6;
         3'd6: sel_v = r7;
         3'd7: sel_v = r8;
      endcase
   end

   for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      hex_to_seg #(
         .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
      ) u_hex_to_seg (
         .hex_i(sel_v[d*NIB_W +: NIB_W]),
         .seg_o(displ_d[d*SEG_W +: SEG_W])
      );
   end

   // Output register: async blank on reset, decoded sample on every edge otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         displ_q <= DISP_BLANK;
      end else begin
         displ_q <= displ_d;
      end
   end

   assign displ = displ_q;

endmodule

// File: tb/tb_seven_seg_controller.sv
// Bench for seven_seg_controller: both polarities checked every cycle against a digit model,
// plus literal pattern checks, async reset, glitch and unselected-register cases.
module tb_seven_seg_controller;

   logic        clk;
   logic        clk_en;
   logic        rst;
   logic [2:0]  sw;
   logic [15:0] r [8];
   logic [27:0] displ_al;
   logic [27:0] displ_ah;

   int total;
   int bad;
   bit chk_on;

   logic [6:0] tbl [16];

   seven_seg_controller #(.SEG_ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst(rst), .sw(sw),
      .r1(r[0]), .r2(r[1]), .r3(r[2]), .r4(r[3]),
      .r5(r[4]), .r6(r[5]), .r7(r[6]), .r8(r[7]),
      .displ(displ_al)
   );

   seven_seg_controller #(.SEG_ACTIVE_LOW(1'b0)) dut_ah (
      .clk(clk), .rst(rst), .sw(sw),
      .r1(r[0]), .r2(r[1]), .r3(r[2]), .r4(r[3]),
      .r5(r[4]), .r6(r[5]), .r7(r[6]), .r8(r[7]),
      .displ(displ_ah)
   );

   always #5 if (clk_en) clk = ~clk;

   function automatic logic [27:0] model(input logic [15:0] v, input bit al);
      logic [27:0] res;
      int          nib;
      res = '0;
      for (int d = 0; d < 4; d++) begin
         nib = (int'(v) / (16 ** d)) % 16;
         res[7*d +: 7] = al ? tbl[nib] : ~tbl[nib];
      end
      return res;
   endfunction

   task automatic chk(input string name, input logic [27:0] act, input logic [27:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_regs();
      for (int i = 0; i < 8; i++) r[i] = 16'h0000;
   endtask

   task automatic edge_then_sample();
      @(posedge clk);
      #1;
   endtask

   // Per-cycle compare of both instances against the model using the inputs seen at the edge.
   always @(posedge clk) begin
      logic [27:0] e_al;
      logic [27:0] e_ah;
      if (rst) begin
         e_al = 28'hFFFFFFF;
         e_ah = 28'h0000000;
      end else begin
         e_al = model(r[sw], 1'b1);
         e_ah = model(r[sw], 1'b0);
      end
      #1;
      if (chk_on) begin
         chk("cycle_al", displ_al, e_al);
         chk("cycle_ah", displ_ah, e_ah);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] v;
      logic [6:0]  g;
      logic [15:0] save;
      int          s;

      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      total  = 0;
      bad    = 0;
      chk_on = 0;
      clk    = 1'b0;
      clk_en = 1'b0;
      rst    = 1'b0;
      sw     = 3'd0;
      clear_regs();

      // Model pinned by hand-computed values.
      chk("model_0001", model(16'h0001, 1'b1), {7'h40, 7'h40, 7'h40, 7'h79});
      chk("model_beef", model(16'hBEEF, 1'b1), {7'h03, 7'h06, 7'h06, 7'h0E});
      chk("model_beef_ah", model(16'hBEEF, 1'b0), ~{7'h03, 7'h06, 7'h06, 7'h0E});

      // Reset with the clock stopped.
      #3 rst = 1'b1;
      #1;
      chk("rst_noclk_al", displ_al, 28'hFFFFFFF);
      chk("rst_noclk_ah", displ_ah, 28'h0000000);

      clk_en = 1'b1;
      chk_on = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      @(negedge clk);
      clear_regs(); sw = 3'd0; r[0] = 16'h0001;
      edge_then_sample();
      chk("r1_0001", displ_al, {7'h40, 7'h40, 7'h40, 7'h79});

      @(negedge clk);
      sw = 3'd1; r[0] = 16'h0000; r[1] = 16'h0002;
      edge_then_sample();
      chk("r2_0002", displ_al, {7'h40, 7'h40, 7'h40, 7'h24});
      chk("r2_0002_ah", displ_ah, ~{7'h40, 7'h40, 7'h40, 7'h24});

      for (int k = 2; k < 8; k++) begin
         @(negedge clk);
         clear_regs(); sw = 3'(k);
         edge_then_sample();
         @(negedge clk);
         r[k] = 16'h0001; sw = 3'(k);
         #1;
         chk("sweep_before", displ_al, {4{7'h40}});
         edge_then_sample();
         chk("sweep_after", displ_al, {7'h40, 7'h40, 7'h40, 7'h79});
      end

      @(negedge clk);
      clear_regs(); sw = 3'd3; r[3] = 16'hBEEF;
      edge_then_sample();
      chk("r4_beef", displ_al, {7'h03, 7'h06, 7'h06, 7'h0E});
      @(negedge clk);
      r[0] = 16'h1234;
      edge_then_sample();
      chk("unsel_r1", displ_al, {7'h03, 7'h06, 7'h06, 7'h0E});

      // Every nibble on every digit; other digits hold 0.
      for (int pos = 0; pos < 4; pos++) begin
         for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            clear_regs(); sw = 3'd5;
            v = 16'(n) << (4 * pos);
            r[5] = v;
            edge_then_sample();
            g = displ_al[7*pos +: 7];
            chk("nib_al", {21'h0, g}, {21'h0, tbl[n]});
            g = displ_ah[7*pos +: 7];
            chk("nib_ah", {21'h0, g}, {21'h0, ~tbl[n]});
         end
      end

      // Glitch between edges on the selected register must not reach the display.
      @(negedge clk);
      sw = 3'd2; r[2] = 16'hA5C3;
      edge_then_sample();
      @(negedge clk);
      #1 r[2] = 16'h0F0F;
      #1;
      chk("glitch_hold", displ_al, model(16'hA5C3, 1'b1));
      #1 r[2] = 16'hA5C3;
      edge_then_sample();
      chk("glitch_after", displ_al, model(16'hA5C3, 1'b1));

      // Async reset mid-operation drops the pending sample.
      @(negedge clk);
      sw = 3'd6; r[6] = 16'h7E81;
      #2 rst = 1'b1;
      #1;
      chk("rst_async_al", displ_al, 28'hFFFFFFF);
      chk("rst_async_ah", displ_ah, 28'h0000000);
      edge_then_sample();
      chk("rst_hold", displ_al, 28'hFFFFFFF);
      @(negedge clk);
      rst = 1'b0;
      sw = 3'd4; r[4] = 16'h3C69;
      edge_then_sample();
      chk("rst_release", displ_al, model(16'h3C69, 1'b1));

      // Random traffic, including simultaneous sw/register changes and glitches.
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         s = $urandom_range(0, 7);
         sw = 3'(s);
         if ($urandom_range(0, 3) == 0) r[s] = 16'($urandom);
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 4) == 0) r[i] = 16'($urandom);
         end
         if ($urandom_range(0, 7) == 0) begin
            save = r[s];
            #1 r[s] = 16'($urandom);
            #1 r[s] = save;
         end
      end

      @(negedge clk);
      chk_on = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
